// File: rtl/mem_wb_lsu.sv
// mem_wb_lsu: memory-stage load/store responder for the 3-stage RV32I pipeline.
// Accepts the X stage's memory request, issues it on a valid/ready data-memory
// port with byte-lane alignment and write mask, waits for read data on loads,
// and extends the selected lane for writeback. Holds the front of the pipeline
// while a transaction is outstanding and aborts after TIMEOUT busy cycles.
//
// Ports:
//   clk, reset                  core clock, synchronous active-high reset
//   x_valid/x_is_load/x_is_store/x_funct3/x_addr/x_store_data/x_rd
//                               memory request from the X stage
//   dmem_req_valid/ready        request handshake; dmem_addr/we/din request payload
//   dmem_resp_valid/dmem_dout   read response
//   stall                       hold PC and X-stage registers
//   wb_valid/wb_rd/wb_data      load writeback (one-cycle pulse)
//   misalign                    one-cycle pulse: misaligned access dropped
//   err                         one-cycle pulse: timeout abort
module mem_wb_lsu #(
    parameter int TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        x_valid,
    input  logic        x_is_load,
    input  logic        x_is_store,
    input  logic [2:0]  x_funct3,
    input  logic [31:0] x_addr,
    input  logic [31:0] x_store_data,
    input  logic [4:0]  x_rd,
    output logic        dmem_req_valid,
    input  logic        dmem_req_ready,
    output logic [31:0] dmem_addr,
    output logic [3:0]  dmem_we,
    output logic [31:0] dmem_din,
    input  logic        dmem_resp_valid,
    input  logic [31:0] dmem_dout,
    output logic        stall,
    output logic        wb_valid,
    output logic [4:0]  wb_rd,
    output logic [31:0] wb_data,
    output logic        misalign,
    output logic        err
);

    typedef enum logic [1:0] {IDLE, REQ, RESP} state_t;

    state_t      state;
    logic        is_load_q;
    logic [2:0]  funct3_q;
    logic [1:0]  lsb_q;
    logic [4:0]  rd_q;
    logic [31:0] cnt;

    logic mem_op, op_load, bad_align, accept, busy;
    logic store_done, resp_done, timeout_hit;

    // Byte-write mask for a store; undefined store encodings write nothing.
    function automatic logic [3:0] store_mask(input logic [2:0] f3, input logic [1:0] lsb);
        case (f3)
            3'b000:  return 4'b0001 << lsb;
            3'b001:  return lsb[1] ? 4'b1100 : 4'b0011;
            3'b010:  return 4'b1111;
            default: return 4'b0000;
        endcase
    endfunction

    // Replicate the store operand so every lane the mask may enable carries it.
    function automatic logic [31:0] store_lanes(input logic [2:0] f3, input logic [31:0] data);
        case (f3)
            3'b000:  return {4{data[7:0]}};
            3'b001:  return {2{data[15:0]}};
            default: return data;
        endcase
    endfunction

    // Halfword needs addr[0]=0, word needs addr[1:0]=0. Undefined load
    // encodings behave as LW, so they get the word check too.
    function automatic logic misaligned(input logic load, input logic [2:0] f3,
                                        input logic [1:0] lsb);
        logic half, word;
        half = (f3[1:0] == 2'b01) && (load || !f3[2]);
        word = (f3[1:0] == 2'b10 && (load || !f3[2])) || (load && f3[1:0] == 2'b11);
        return (half && lsb[0]) || (word && lsb != 2'b00);
    endfunction

    // Lane select and sign/zero extension; undefined load encodings return the word.
    function automatic logic [31:0] load_extend(input logic [2:0] f3, input logic [1:0] lsb,
                                                input logic [31:0] word);
        logic [31:0] shifted;
        logic [7:0]  b;
        logic [15:0] h;
        shifted = word >> {lsb, 3'b000};
        b       = shifted[7:0];
        h       = lsb[1] ? word[31:16] : word[15:0];
        case (f3)
            3'b000:  return {{24{b[7]}}, b};
            3'b100:  return {24'b0, b};
            3'b001:  return {{16{h[15]}}, h};
            3'b101:  return {16'b0, h};
            default: return word;
        endcase
    endfunction

    always_comb begin
        mem_op      = x_valid && (x_is_load || x_is_store);
        op_load     = x_is_load && !x_is_store;   // both set: store wins
        bad_align   = misaligned(op_load, x_funct3, x_addr[1:0]);
        accept      = (state == IDLE) && mem_op && !bad_align;
        busy        = (state != IDLE);
        store_done  = (state == REQ) && dmem_req_ready && !is_load_q;
        resp_done   = (state == RESP) && dmem_resp_valid;
        timeout_hit = (TIMEOUT != 0) && busy && (cnt == 32'(TIMEOUT - 1));
        // Release the X stage in the completing or aborting cycle so the next
        // op is presented to IDLE on the following cycle.
        stall       = !reset && (accept || (busy && !store_done && !resp_done && !timeout_hit));
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state          <= IDLE;
            is_load_q      <= 1'b0;
            funct3_q       <= 3'b000;
            lsb_q          <= 2'b00;
            rd_q           <= 5'd0;
            cnt            <= 32'd0;
            dmem_req_valid <= 1'b0;
            dmem_addr      <= 32'd0;
            dmem_we        <= 4'b0000;
            dmem_din       <= 32'd0;
            wb_valid       <= 1'b0;
            wb_rd          <= 5'd0;
            wb_data        <= 32'd0;
            misalign       <= 1'b0;
            err            <= 1'b0;
        end else begin
            wb_valid <= 1'b0;
            misalign <= 1'b0;
            err      <= 1'b0;
            case (state)
                IDLE: begin
                    cnt <= 32'd0;
                    if (accept) begin
                        is_load_q      <= op_load;
                        funct3_q       <= x_funct3;
                        lsb_q          <= x_addr[1:0];
                        rd_q           <= x_rd;
                        dmem_req_valid <= 1'b1;
                        dmem_addr      <= {x_addr[31:2], 2'b00};
                        dmem_we        <= op_load ? 4'b0000 : store_mask(x_funct3, x_addr[1:0]);
                        dmem_din       <= op_load ? 32'd0 : store_lanes(x_funct3, x_store_data);
                        state          <= REQ;
                    end else if (mem_op) begin
                        misalign <= 1'b1;
                    end
                end
                REQ: begin
                    cnt <= cnt + 32'd1;
                    if (store_done) begin
                        dmem_req_valid <= 1'b0;
                        state          <= IDLE;
                    end else if (timeout_hit) begin
                        dmem_req_valid <= 1'b0;
                        err            <= 1'b1;
                        state          <= IDLE;
                    end else if (dmem_req_ready) begin
                        dmem_req_valid <= 1'b0;
                        state          <= RESP;
                    end
                end
                RESP: begin
                    cnt <= cnt + 32'd1;
                    if (resp_done) begin
                        wb_valid <= 1'b1;
                        wb_rd    <= rd_q;
                        wb_data  <= load_extend(funct3_q, lsb_q, dmem_dout);
                        state    <= IDLE;
                    end else if (timeout_hit) begin
                        err   <= 1'b1;
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_wb_lsu.sv
// Directed testbench for mem_wb_lsu with a writeback scoreboard.
module tb_mem_wb_lsu;

    logic        clk;
    logic        reset;
    logic        x_valid, x_is_load, x_is_store;
    logic [2:0]  x_funct3;
    logic [31:0] x_addr, x_store_data;
    logic [4:0]  x_rd;
    logic        dmem_req_valid, dmem_req_ready;
    logic [31:0] dmem_addr;
    logic [3:0]  dmem_we;
    logic [31:0] dmem_din;
    logic        dmem_resp_valid;
    logic [31:0] dmem_dout;
    logic        stall, wb_valid;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic        misalign, err;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic [4:0]  rd;
        logic [31:0] data;
    } wb_t;
    wb_t sb[$];

    mem_wb_lsu #(.TIMEOUT(8)) dut (
        .clk(clk), .reset(reset),
        .x_valid(x_valid), .x_is_load(x_is_load), .x_is_store(x_is_store),
        .x_funct3(x_funct3), .x_addr(x_addr), .x_store_data(x_store_data), .x_rd(x_rd),
        .dmem_req_valid(dmem_req_valid), .dmem_req_ready(dmem_req_ready),
        .dmem_addr(dmem_addr), .dmem_we(dmem_we), .dmem_din(dmem_din),
        .dmem_resp_valid(dmem_resp_valid), .dmem_dout(dmem_dout),
        .stall(stall), .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data),
        .misalign(misalign), .err(err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Inputs change 2 time units after the rising edge; outputs are sampled 1 later.
    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic clr_x();
        x_valid = 1'b0; x_is_load = 1'b0; x_is_store = 1'b0;
        x_funct3 = 3'b000; x_addr = 32'd0; x_store_data = 32'd0; x_rd = 5'd0;
    endtask

    // Scoreboard consumer: every writeback pulse must match the oldest expectation.
    always @(negedge clk) begin
        wb_t e;
        int  depth;
        if (!reset && wb_valid) begin
            depth = sb.size();
            checks++;
            assert (depth != 0) else begin
                errors++;
                $error("FAIL unexpected_wb: observed rd=%0d data=%h expected no writeback", wb_rd, wb_data);
            end
            if (depth != 0) begin
                e = sb.pop_front();
                chk("wb_data", wb_data, e.data);
                chk("wb_rd", {27'd0, wb_rd}, {27'd0, e.rd});
            end
        end
    end

    task automatic drain();
        for (int i = 0; i < 8 && sb.size() != 0; i++) step();
        chk("wb_drain", 32'(sb.size()), 32'd0);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_req_valid"}, {31'd0, dmem_req_valid}, 32'd0);
        chk({tag, "_addr"}, dmem_addr, 32'd0);
        chk({tag, "_we"}, {28'd0, dmem_we}, 32'd0);
        chk({tag, "_din"}, dmem_din, 32'd0);
        chk({tag, "_stall"}, {31'd0, stall}, 32'd0);
        chk({tag, "_wb_valid"}, {31'd0, wb_valid}, 32'd0);
        chk({tag, "_wb_rd"}, {27'd0, wb_rd}, 32'd0);
        chk({tag, "_wb_data"}, wb_data, 32'd0);
        chk({tag, "_misalign"}, {31'd0, misalign}, 32'd0);
        chk({tag, "_err"}, {31'd0, err}, 32'd0);
    endtask

    // Load: accept, REQ with ready, gap-1 waiting RESP cycles, then response.
    task automatic do_load(input logic [2:0] f3, input logic [31:0] addr, input logic [4:0] rd,
                           input logic [31:0] dout, input logic [31:0] exp, input int gap);
        sb.push_back({rd, exp});
        x_valid = 1'b1; x_is_load = 1'b1; x_is_store = 1'b0;
        x_funct3 = f3; x_addr = addr; x_rd = rd; dmem_req_ready = 1'b1;
        #1 chk("ld_acc_stall", {31'd0, stall}, 32'd1);
        step();
        clr_x();
        #1;
        chk("ld_req_valid", {31'd0, dmem_req_valid}, 32'd1);
        chk("ld_addr", dmem_addr, {addr[31:2], 2'b00});
        chk("ld_we", {28'd0, dmem_we}, 32'd0);
        chk("ld_req_stall", {31'd0, stall}, 32'd1);
        step();
        dmem_req_ready = 1'b0;
        for (int i = 0; i < gap - 1; i++) begin
            #1;
            chk("ld_wait_stall", {31'd0, stall}, 32'd1);
            chk("ld_wait_req", {31'd0, dmem_req_valid}, 32'd0);
            step();
        end
        dmem_resp_valid = 1'b1; dmem_dout = dout;
        #1 chk("ld_resp_stall", {31'd0, stall}, 32'd0);
        step();
        dmem_resp_valid = 1'b0; dmem_dout = $urandom;
        drain();
    endtask

    // Store: accept, then `waits` cycles with ready low, then ready.
    task automatic do_store(input logic [2:0] f3, input logic [31:0] addr, input logic [31:0] data,
                            input logic [3:0] exp_we, input logic [31:0] exp_din, input int waits);
        x_valid = 1'b1; x_is_load = 1'b0; x_is_store = 1'b1;
        x_funct3 = f3; x_addr = addr; x_store_data = data; dmem_req_ready = (waits == 0);
        #1 chk("st_acc_stall", {31'd0, stall}, 32'd1);
        step();
        clr_x();
        for (int i = 0; i <= waits; i++) begin
            dmem_req_ready = (i == waits);
            #1;
            chk("st_req_valid", {31'd0, dmem_req_valid}, 32'd1);
            chk("st_addr", dmem_addr, {addr[31:2], 2'b00});
            chk("st_we", {28'd0, dmem_we}, {28'd0, exp_we});
            chk("st_din", dmem_din, exp_din);
            chk("st_stall", {31'd0, stall}, (i == waits) ? 32'd0 : 32'd1);
            step();
        end
        dmem_req_ready = 1'b0;
        #1;
        chk("st_done_req", {31'd0, dmem_req_valid}, 32'd0);
        chk("st_done_stall", {31'd0, stall}, 32'd0);
        chk("st_no_wb", {31'd0, wb_valid}, 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "global timeout");
    end

    initial begin
        reset = 1'b1;
        clr_x();
        dmem_req_ready = 1'b0; dmem_resp_valid = 1'b0; dmem_dout = 32'd0;
        step();
        step();
        #1 chk_all_zero("rst");
        reset = 1'b0;
        step();

        // SB to byte lane 3
        do_store(3'b000, 32'h0000_1003, 32'hA5A5_A5C3, 4'b1000, 32'hC3C3_C3C3, 0);
        step();

        // LB / LBU / LH with response two cycles after ready
        do_load(3'b000, 32'h0000_2001, 5'd5, 32'h1234_80FF, 32'hFFFF_FF80, 2);
        do_load(3'b100, 32'h0000_2001, 5'd6, 32'h1234_80FF, 32'h0000_0080, 2);
        do_load(3'b001, 32'h0000_2002, 5'd10, 32'h8001_7FFF, 32'hFFFF_8001, 2);
        do_load(3'b101, 32'h0000_2000, 5'd11, 32'h8001_8FFF, 32'h0000_8FFF, 1);

        // Misaligned LW is dropped
        x_valid = 1'b1; x_is_load = 1'b1; x_funct3 = 3'b010; x_addr = 32'h0000_2003; x_rd = 5'd8;
        #1 chk("mis_stall", {31'd0, stall}, 32'd0);
        step();
        clr_x();
        #1;
        chk("mis_pulse", {31'd0, misalign}, 32'd1);
        chk("mis_no_req", {31'd0, dmem_req_valid}, 32'd0);
        step();
        #1 chk("mis_pulse_end", {31'd0, misalign}, 32'd0);
        step();

        // SW with ready held low five cycles, then SH upper half
        do_store(3'b010, 32'h0000_3000, 32'hDEAD_BEEF, 4'b1111, 32'hDEAD_BEEF, 5);
        do_store(3'b001, 32'h0000_3006, 32'h1234_ABCD, 4'b1100, 32'hABCD_ABCD, 1);
        // Undefined store encoding: request issued with empty mask
        do_store(3'b011, 32'h0000_3008, 32'h5555_AAAA, 4'b0000, 32'h5555_AAAA, 0);
        step();

        // Timeout: load accepted, no response
        x_valid = 1'b1; x_is_load = 1'b1; x_funct3 = 3'b010; x_addr = 32'h0000_4000; x_rd = 5'd7;
        dmem_req_ready = 1'b1;
        #1 chk("to_acc_stall", {31'd0, stall}, 32'd1);
        step();
        clr_x();
        #1 chk("to_req_stall", {31'd0, stall}, 32'd1);
        step();
        dmem_req_ready = 1'b0;
        for (int i = 2; i <= 7; i++) begin
            #1;
            chk("to_busy_stall", {31'd0, stall}, 32'd1);
            chk("to_busy_err", {31'd0, err}, 32'd0);
            step();
        end
        #1 chk("to_last_stall", {31'd0, stall}, 32'd0);
        step();
        #1;
        chk("to_err", {31'd0, err}, 32'd1);
        chk("to_req_dropped", {31'd0, dmem_req_valid}, 32'd0);
        chk("to_idle_stall", {31'd0, stall}, 32'd0);
        step();
        #1 chk("to_err_end", {31'd0, err}, 32'd0);
        drain();

        // Next LW completes normally; then a load to x0
        do_load(3'b010, 32'h0000_4004, 5'd9, 32'hCAFE_F00D, 32'hCAFE_F00D, 1);
        do_load(3'b011, 32'h0000_7000, 5'd0, 32'h1357_2468, 32'h1357_2468, 1);

        // Reset while in RESP, response arrives after release
        x_valid = 1'b1; x_is_load = 1'b1; x_funct3 = 3'b001; x_addr = 32'h0000_5000; x_rd = 5'd3;
        dmem_req_ready = 1'b1;
        step();
        clr_x();
        step();
        dmem_req_ready = 1'b0;
        #1 chk("rr_resp_stall", {31'd0, stall}, 32'd1);
        reset = 1'b1;
        step();
        reset = 1'b0;
        dmem_resp_valid = 1'b1; dmem_dout = 32'hFFFF_FFFF;
        #1 chk_all_zero("rr");
        step();
        dmem_resp_valid = 1'b0;
        #1;
        chk("rr_no_wb", {31'd0, wb_valid}, 32'd0);
        chk("rr_no_stall", {31'd0, stall}, 32'd0);
        do_load(3'b100, 32'h0000_5003, 5'd4, 32'hAB00_0000, 32'h0000_00AB, 1);

        step();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
